// File: rtl/ex_mem_stage.sv
// ex_mem_stage: EX->MEM pipeline boundary with a valid/ready handshake and a
// two-entry (main + skid) buffer.
// The main entry drives the outputs. A beat goes into the skid entry only
// when MEM stalls while EX is still pushing. in_ready depends only on
// registered state, so there is no combinational path from out_ready.
// A synchronous flush drops both entries. The payload registers keep their
// contents.
// Optional build macro EX_MEM_FWD_EN adds the fwd_valid/fwd_rd/fwd_data
// forwarding outputs. They are taken from the main entry only.
module ex_mem_stage #(
  parameter int DATA_W     = 8,
  parameter int REG_ADDR_W = 3,
  parameter int MEM_ADDR_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     alu_result_in,
  input  logic [DATA_W-1:0]     val_rs2_in,
  input  logic [REG_ADDR_W-1:0] rd_in,
  input  logic [MEM_ADDR_W-1:0] mem_addr_in,
  input  logic                  we_ram_in,
  input  logic                  we_rf_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     alu_result_out,
  output logic [DATA_W-1:0]     val_rs2_out,
  output logic [REG_ADDR_W-1:0] rd_out,
  output logic [MEM_ADDR_W-1:0] mem_addr_out,
  output logic                  we_ram_out,
`ifdef EX_MEM_FWD_EN
  output logic                  fwd_valid,
  output logic [REG_ADDR_W-1:0] fwd_rd,
  output logic [DATA_W-1:0]     fwd_data,
`endif
  output logic                  we_rf_out
);

  // One instruction's worth of EX results.
  typedef struct packed {
    logic [DATA_W-1:0]     alu;
    logic [DATA_W-1:0]     rs2;
    logic [REG_ADDR_W-1:0] rd;
    logic [MEM_ADDR_W-1:0] addr;
    logic                  we_ram;
    logic                  we_rf;
  } payload_t;

  // Buffer occupancy. The state "skid only" cannot occur because the skid
  // always drains into main first.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_MAIN  = 2'd1,
    ST_FULL  = 2'd2
  } occ_t;

  occ_t     r_state;
  occ_t     w_state_nxt;
  payload_t r_main;
  payload_t r_skid;
  payload_t w_in_beat;

  logic w_main_valid;
  logic w_skid_valid;
  logic w_accept;
  logic w_drain;
  logic w_ld_main_in;
  logic w_ld_main_skid;
  logic w_ld_skid_in;

  assign w_in_beat.alu    = alu_result_in;
  assign w_in_beat.rs2    = val_rs2_in;
  assign w_in_beat.rd     = rd_in;
  assign w_in_beat.addr   = mem_addr_in;
  assign w_in_beat.we_ram = we_ram_in;
  assign w_in_beat.we_rf  = we_rf_in;

  assign w_main_valid = (r_state == ST_MAIN) || (r_state == ST_FULL);
  assign w_skid_valid = (r_state == ST_FULL);

  // Handshake terms. in_ready comes from registered state only.
  assign in_ready = ~w_skid_valid;
  assign w_accept = in_valid & in_ready;
  assign w_drain  = w_main_valid & out_ready;

  // Occupancy state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next occupancy and payload steering. Flush overrides accept and drain.
  always_comb begin
    w_state_nxt    = r_state;
    w_ld_main_in   = 1'b0;
    w_ld_main_skid = 1'b0;
    w_ld_skid_in   = 1'b0;
    if (flush) begin
      w_state_nxt = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            w_state_nxt  = ST_MAIN;
            w_ld_main_in = 1'b1;
          end
        end
        ST_MAIN: begin
          if (w_accept && w_drain) begin
            w_ld_main_in = 1'b1;
          end else if (w_accept) begin
            w_state_nxt  = ST_FULL;
            w_ld_skid_in = 1'b1;
          end else if (w_drain) begin
            w_state_nxt = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (w_drain) begin
            w_state_nxt    = ST_MAIN;
            w_ld_main_skid = 1'b1;
          end
        end
        default: begin
          w_state_nxt = ST_EMPTY;
        end
      endcase
    end
  end

  // Main payload. It holds its value when not loaded so the outputs stay
  // stable while idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_main <= '0;
    end else if (w_ld_main_in) begin
      r_main <= w_in_beat;
    end else if (w_ld_main_skid) begin
      r_main <= r_skid;
    end
  end

  // Skid payload. It captures a beat that arrives while MEM stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_skid <= '0;
    end else if (w_ld_skid_in) begin
      r_skid <= w_in_beat;
    end
  end

  assign out_valid      = w_main_valid;
  assign alu_result_out = r_main.alu;
  assign val_rs2_out    = r_main.rs2;
  assign rd_out         = r_main.rd;
  assign mem_addr_out   = r_main.addr;
  assign we_ram_out     = r_main.we_ram & w_main_valid;
  assign we_rf_out      = r_main.we_rf & w_main_valid;

`ifdef EX_MEM_FWD_EN
  assign fwd_valid = w_main_valid & r_main.we_rf;
  assign fwd_rd    = r_main.rd;
  assign fwd_data  = r_main.alu;
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// tb_ex_mem_stage: directed bench for ex_mem_stage using the default
// parameters. Each step drives inputs #1 after a rising edge and checks the
// registered outputs #1 after the next rising edge.
module tb_ex_mem_stage;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] alu_result_in;
  logic [7:0] val_rs2_in;
  logic [2:0] rd_in;
  logic [7:0] mem_addr_in;
  logic       we_ram_in;
  logic       we_rf_in;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] alu_result_out;
  logic [7:0] val_rs2_out;
  logic [2:0] rd_out;
  logic [7:0] mem_addr_out;
  logic       we_ram_out;
  logic       we_rf_out;
`ifdef EX_MEM_FWD_EN
  logic       fwd_valid;
  logic [2:0] fwd_rd;
  logic [7:0] fwd_data;
`endif

  int total = 0;
  int bad   = 0;

  ex_mem_stage #(.DATA_W(8), .REG_ADDR_W(3), .MEM_ADDR_W(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .alu_result_in  (alu_result_in),
    .val_rs2_in     (val_rs2_in),
    .rd_in          (rd_in),
    .mem_addr_in    (mem_addr_in),
    .we_ram_in      (we_ram_in),
    .we_rf_in       (we_rf_in),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .alu_result_out (alu_result_out),
    .val_rs2_out    (val_rs2_out),
    .rd_out         (rd_out),
    .mem_addr_out   (mem_addr_out),
    .we_ram_out     (we_ram_out),
`ifdef EX_MEM_FWD_EN
    .fwd_valid      (fwd_valid),
    .fwd_rd         (fwd_rd),
    .fwd_data       (fwd_data),
`endif
    .we_rf_out      (we_rf_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] alu, input logic [7:0] rs2,
                       input logic [2:0] rd, input logic [7:0] addr,
                       input logic wram, input logic wrf);
    in_valid      = v;
    alu_result_in = alu;
    val_rs2_in    = rs2;
    rd_in         = rd;
    mem_addr_in   = addr;
    we_ram_in     = wram;
    we_rf_in      = wrf;
  endtask

  task automatic idle();
    drive(1'b0, 8'h00, 8'h00, 3'd0, 8'h00, 1'b0, 1'b0);
  endtask

  // Guard against a hung run.
  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset held with random inputs.
    rst   = 1'b1;
    flush = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'($urandom), 8'($urandom), 8'($urandom), 3'($urandom), 8'($urandom),
            1'($urandom), 1'($urandom));
      out_ready = 1'($urandom);
      tick();
    end
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_we_ram", 32'(we_ram_out), 32'd0);
    chk("rst_we_rf", 32'(we_rf_out), 32'd0);
    chk("rst_alu", 32'(alu_result_out), 32'h00);
    chk("rst_rs2", 32'(val_rs2_out), 32'h00);
    chk("rst_rd", 32'(rd_out), 32'd0);
    chk("rst_addr", 32'(mem_addr_out), 32'h00);
    idle();
    out_ready = 1'b1;
    rst = 1'b0;
    tick();
    chk("rst_rel_in_ready", 32'(in_ready), 32'd1);
    chk("rst_rel_out_valid", 32'(out_valid), 32'd0);

    // Streaming: one beat per cycle, one cycle of latency.
    drive(1'b1, 8'h10, 8'h20, 3'd0, 8'h80, 1'b0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("stream_valid", 32'(out_valid), 32'd1);
      chk("stream_alu", 32'(alu_result_out), 32'(8'h10 + k));
      chk("stream_rs2", 32'(val_rs2_out), 32'(8'h20 + k));
      chk("stream_rd", 32'(rd_out), 32'(k));
      chk("stream_addr", 32'(mem_addr_out), 32'(8'h80 + k));
      chk("stream_we_rf", 32'(we_rf_out), 32'd1);
      chk("stream_in_ready", 32'(in_ready), 32'd1);
      if (k < 4) drive(1'b1, 8'(8'h11 + k), 8'(8'h21 + k), 3'(k + 1), 8'(8'h81 + k), 1'b0, 1'b1);
      else idle();
    end
    tick();
    chk("stream_end_valid", 32'(out_valid), 32'd0);
    chk("stream_end_we_rf", 32'(we_rf_out), 32'd0);
    chk("stream_hold_alu", 32'(alu_result_out), 32'h14);

    // Back-pressure: two beats fill main and skid, the third is refused.
    out_ready = 1'b0;
    drive(1'b1, 8'hA1, 8'h01, 3'd1, 8'h11, 1'b0, 1'b0);
    tick();
    chk("bp_m_valid", 32'(out_valid), 32'd1);
    chk("bp_m_in_ready", 32'(in_ready), 32'd1);
    drive(1'b1, 8'hA2, 8'h02, 3'd2, 8'h12, 1'b0, 1'b0);
    tick();
    chk("bp_f_in_ready", 32'(in_ready), 32'd0);
    chk("bp_f_alu", 32'(alu_result_out), 32'hA1);
    drive(1'b1, 8'hA3, 8'h03, 3'd3, 8'h13, 1'b0, 1'b0);
    tick();
    chk("bp_stall_in_ready", 32'(in_ready), 32'd0);
    chk("bp_stall_alu", 32'(alu_result_out), 32'hA1);
    out_ready = 1'b1;
    tick();
    chk("bp_drain1_alu", 32'(alu_result_out), 32'hA2);
    chk("bp_drain1_rd", 32'(rd_out), 32'd2);
    chk("bp_drain1_in_ready", 32'(in_ready), 32'd1);
    tick();
    chk("bp_drain2_alu", 32'(alu_result_out), 32'hA3);
    chk("bp_drain2_valid", 32'(out_valid), 32'd1);
    idle();
    tick();
    chk("bp_empty_valid", 32'(out_valid), 32'd0);

    // Flush from the full state, with a beat offered during the flush.
    out_ready = 1'b0;
    drive(1'b1, 8'hB1, 8'h00, 3'd4, 8'h21, 1'b1, 1'b0);
    tick();
    drive(1'b1, 8'hB2, 8'h00, 3'd5, 8'h22, 1'b1, 1'b0);
    tick();
    chk("fl_full_in_ready", 32'(in_ready), 32'd0);
    chk("fl_full_we_ram", 32'(we_ram_out), 32'd1);
    drive(1'b1, 8'h55, 8'h00, 3'd6, 8'h55, 1'b1, 1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    idle();
    chk("fl_out_valid", 32'(out_valid), 32'd0);
    chk("fl_we_ram", 32'(we_ram_out), 32'd0);
    chk("fl_in_ready", 32'(in_ready), 32'd1);
    chk("fl_payload_kept", 32'(alu_result_out), 32'hB1);
    out_ready = 1'b1;
    tick();
    chk("fl_after_valid", 32'(out_valid), 32'd0);

    // Flush from main-only, where the offered beat would otherwise be taken.
    out_ready = 1'b0;
    drive(1'b1, 8'hC1, 8'h00, 3'd1, 8'h31, 1'b1, 1'b0);
    tick();
    drive(1'b1, 8'h55, 8'h00, 3'd6, 8'h55, 1'b1, 1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    idle();
    chk("fl2_out_valid", 32'(out_valid), 32'd0);
    chk("fl2_in_ready", 32'(in_ready), 32'd1);
    chk("fl2_alu_not_55", 32'(alu_result_out), 32'hC1);
    out_ready = 1'b1;
    tick();
    chk("fl2_no_skid_leak", 32'(out_valid), 32'd0);

    // Simultaneous accept and drain in the main-only state.
    drive(1'b1, 8'hD1, 8'h00, 3'd2, 8'h41, 1'b0, 1'b1);
    tick();
    chk("ad_first_alu", 32'(alu_result_out), 32'hD1);
    drive(1'b1, 8'hD2, 8'h00, 3'd3, 8'h42, 1'b1, 1'b0);
    tick();
    chk("ad_replace_alu", 32'(alu_result_out), 32'hD2);
    chk("ad_skid_empty", 32'(in_ready), 32'd1);
    chk("ad_we_ram", 32'(we_ram_out), 32'd1);
    chk("ad_we_rf", 32'(we_rf_out), 32'd0);
    idle();
    tick();
    chk("ad_empty", 32'(out_valid), 32'd0);

`ifdef EX_MEM_FWD_EN
    // Forwarding taken from the main entry.
    drive(1'b1, 8'h7E, 8'h00, 3'd3, 8'h50, 1'b0, 1'b1);
    tick();
    chk("fwd_valid", 32'(fwd_valid), 32'd1);
    chk("fwd_rd", 32'(fwd_rd), 32'd3);
    chk("fwd_data", 32'(fwd_data), 32'h7E);
    drive(1'b1, 8'h7E, 8'h00, 3'd3, 8'h50, 1'b0, 1'b0);
    tick();
    chk("fwd_no_we_rf", 32'(fwd_valid), 32'd0);
    idle();
    tick();
`endif

    // Asynchronous reset in the middle of a cycle.
    out_ready = 1'b0;
    drive(1'b1, 8'h66, 8'h77, 3'd7, 8'h88, 1'b1, 1'b1);
    tick();
    chk("ar_pre_valid", 32'(out_valid), 32'd1);
    idle();
    #2;
    rst = 1'b1;
    #1;
    chk("ar_valid_drop", 32'(out_valid), 32'd0);
    chk("ar_alu_clear", 32'(alu_result_out), 32'h00);
    chk("ar_we_ram", 32'(we_ram_out), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
    chk("ar_after_valid", 32'(out_valid), 32'd0);
    chk("ar_after_in_ready", 32'(in_ready), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
Parametrised EX->MEM pipeline boundary register. It replaces the fixed 8-bit EX/MEM latch with a valid/ready handshake, a two-entry skid buffer, and a synchronous flush. It sits between the ALU/execute stage and the data-memory/writeback stage. Back-pressure from MEM stalls EX without losing or duplicating instructions.

Parameters:
DATA_W, 8, width of alu_result and val_rs2 payloads
REG_ADDR_W, 3, width of destination register index rd
MEM_ADDR_W, 8, width of the data-memory address

Ports:
clk  in  1  clock; all state updates on its rising edge
rst  in  1  asynchronous, active-high reset
flush  in  1  synchronous pipeline flush (branch/exception)
in_valid  in  1  EX presents a valid instruction
in_ready  out  1  stage can accept a beat this cycle
alu_result_in  in  DATA_W  ALU result
val_rs2_in  in  DATA_W  store data
rd_in  in  REG_ADDR_W  destination register
mem_addr_in  in  MEM_ADDR_W  data-memory address
we_ram_in  in  1  memory write enable
we_rf_in  in  1  register-file write enable
out_valid  out  1  output payload valid
out_ready  in  1  MEM accepts the output this cycle
alu_result_out  out  DATA_W  registered ALU result
val_rs2_out  out  DATA_W  registered store data
rd_out  out  REG_ADDR_W  registered destination
mem_addr_out  out  MEM_ADDR_W  registered address
we_ram_out  out  1  write enable, qualified by out_valid
we_rf_out  out  1  write enable, qualified by out_valid

Behaviour:
- Clock/reset: one clock, clk; reset rst is asynchronous and active-high.
- Reset values: all payload registers 0, main_valid=0, skid_valid=0. So out_valid=0, we_ram_out=0, we_rf_out=0, and in_ready=1 once rst deasserts.
- Storage: a main register (drives the outputs) plus one skid register, each with a valid bit.
- Transfer rules: accept = in_valid & in_ready; drain = out_valid & out_ready.
- in_ready = !skid_valid. It is a registered-state function with no combinational path from out_ready.
- Latency: one cycle from accept to out_valid when the stage is empty.
- State transitions (E=empty, M=main only, F=main+skid):
  - E: accept -> M.
  - M: accept & !drain -> F (beat to skid); accept & drain -> M (beat to main); drain only -> E.
  - F: drain -> M (skid moves to main, skid cleared); no drain -> F, in_ready=0.
- Ordering: strict FIFO. The skid entry always leaves after the main entry.
- Data outputs hold their last value while out_valid=0.
- we_ram_out and we_rf_out are forced 0 whenever out_valid=0.
- flush: on the next edge main_valid and skid_valid are cleared.
  - Any beat accepted in the flush cycle is discarded.
  - Payload registers are not cleared by flush.
  - flush overrides accept and drain; a drain coinciding with flush still counts as consumed by MEM.
- rst mid-operation: immediate clear of both valid bits and all payloads, regardless of clk.
- No throughput loss: with out_ready=1 constantly, one beat per cycle, and the skid is never used.

Optional Feature:
Macro EX_MEM_FWD_EN.
- Defined: adds outputs fwd_valid (1), fwd_rd (REG_ADDR_W), fwd_data (DATA_W) for EX-stage operand forwarding.
  - fwd_valid = out_valid & we_rf_out.
  - fwd_rd = rd_out.
  - fwd_data = alu_result_out.
  - All three are combinational from the main register only; the skid entry is never forwarded.
- Not defined: these ports and their logic do not exist.

Test Plan:
1. Reset: hold rst=1 with random inputs -> all outputs 0, in_ready=1 after release; assert rst asynchronously mid-cycle -> out_valid drops without a clk edge.
2. Streaming: out_ready=1, 5 back-to-back beats alu_result_in=0x10..0x14 -> outputs 0x10..0x14 on consecutive cycles, 1-cycle latency, in_ready stays 1.
3. Back-pressure: hold out_ready=0, send 0xA1, 0xA2, then offer 0xA3 -> in_ready=0 after 2 beats and 0xA3 is not taken. Release out_ready -> outputs 0xA1, 0xA2, 0xA3 in order with no duplicates.
4. Flush: stage full (F) with we_ram=1 entries, pulse flush with in_valid=1 carrying 0x55 -> next cycle out_valid=0, we_ram_out=0, in_ready=1, and 0x55 never appears.
5. Simultaneous accept+drain in state M: out_ready=1, in_valid=1 -> main replaced, skid_valid stays 0.
6. EX_MEM_FWD_EN defined: beat rd=3, we_rf=1, alu=0x7E -> fwd_valid=1, fwd_rd=3, fwd_data=0x7E. Same beat with we_rf=0 -> fwd_valid=0.
